header_generator: RTL and testbench

- Produces the candidate block headers for the hash search: a loaded secret key followed by an incrementing decimal nonce, packed as ASCII.
- Output layout is exactly what the downstream suffix decoder parses: byte 0 holds the least-significant digit, digit i sits at byte i, key characters sit directly above the most-significant digit, and unused upper bytes are 0x00.
- Sits between the input byte stream (key) and the hash pipeline. It also emits a binary copy of each nonce for result matching.

---
 rtl/header_generator.sv | 172 +++++++++++++++++
 tb/tb_header_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/header_generator.sv
// Candidate block header source: loaded key followed by an incrementing decimal nonce, packed
// as ASCII with the least-significant digit in byte 0, plus a binary copy of the nonce.
module header_generator #(
  parameter int BLOCK_HEADER_WIDTH = 128,
  parameter int INDEX_WIDTH        = 32,
  parameter int START_VALUE        = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [7:0]                    key_data,
  input  logic                          key_last,
  output logic                          key_ready,
  input  logic                          halt,
  output logic                          header_valid,
  input  logic                          header_ready,
  output logic [BLOCK_HEADER_WIDTH-1:0] header_data,
  output logic [INDEX_WIDTH-1:0]        header_index,
  output logic                          done,
  output logic                          overflow
);

  localparam int W     = BLOCK_HEADER_WIDTH;
  localparam int CHARS = W / 8;
  localparam int CW    = $clog2(CHARS + 2);

  localparam logic [1:0] LOAD_KEY = 2'd0;
  localparam logic [1:0] EMIT     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  function automatic logic [4*CHARS-1:0] start_bcd();
    logic [4*CHARS-1:0] b;
    longint unsigned    v;
    b = '0;
    v = longint'(START_VALUE);
    for (int i = 0; i < CHARS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] start_digits();
    logic [CW-1:0]   d;
    longint unsigned v;
    d = CW'(1);
    v = longint'(START_VALUE) / 10;
    for (int i = 1; i < CHARS; i++) begin
      if (v != 0) begin
        d = CW'(i + 1);
        v = v / 10;
      end
    end
    return d;
  endfunction

  localparam logic [4*CHARS-1:0] START_BCD = start_bcd();
  localparam logic [CW-1:0]      START_N   = start_digits();

  // Key bytes above key_len are always zero, so shifting the key over the digits packs it.
  function automatic logic [W-1:0] pack(input logic [4*CHARS-1:0] b,
                                        input logic [CW-1:0] d,
                                        input logic [W-1:0] k);
    logic [W-1:0] h;
    h = k << (8 * int'(d));
    for (int i = 0; i < CHARS; i++) begin
      if (i < int'(d)) h[8*i +: 8] = {4'h3, b[4*i +: 4]};
    end
    return h;
  endfunction

  logic [1:0]         state;
  logic [W-1:0]       key_reg;
  logic [CW-1:0]      key_len;
  logic [4*CHARS-1:0] bcd;
  logic [CW-1:0]      n;

  logic [4*CHARS-1:0] inc_bcd;
  logic               carry;
  logic [CW-1:0]      inc_n;
  logic               fits;
  logic [CW-1:0]      len_next;
  logic [W-1:0]       key_next;
  logic               start_fits;

  always_comb begin
    inc_bcd = bcd;
    carry   = 1'b1;
    for (int i = 0; i < CHARS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    inc_n = n;
    for (int i = 0; i < CHARS; i++) begin
      if (i == int'(n) && inc_bcd[4*i +: 4] != 4'd0) inc_n = n + CW'(1);
    end
    // A carry out of the top digit can only happen with an empty key and never fits.
    fits = !carry && (int'(inc_n) + int'(key_len) <= CHARS);
    if (int'(key_len) < CHARS - 1) begin
      len_next = key_len + CW'(1);
      key_next = {key_reg[W-9:0], key_data};
    end else begin
      len_next = key_len;
      key_next = key_reg;
    end
    start_fits = (int'(len_next) + int'(START_N) <= CHARS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD_KEY;
      key_reg      <= '0;
      key_len      <= '0;
      bcd          <= '0;
      n            <= '0;
      key_ready    <= 1'b1;
      header_valid <= 1'b0;
      header_data  <= '0;
      header_index <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        LOAD_KEY: begin
          if (key_valid) begin
            key_reg <= key_next;
            key_len <= len_next;
            if (key_last) begin
              bcd          <= START_BCD;
              n            <= START_N;
              header_index <= INDEX_WIDTH'(START_VALUE);
              key_ready    <= 1'b0;
              if (start_fits) begin
                state        <= EMIT;
                header_valid <= 1'b1;
                header_data  <= pack(START_BCD, START_N, key_next);
              end else begin
                state    <= DONE;
                done     <= 1'b1;
                overflow <= 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (header_ready && fits && !halt) begin
            bcd          <= inc_bcd;
            n            <= inc_n;
            header_index <= header_index + INDEX_WIDTH'(1);
            header_data  <= pack(inc_bcd, inc_n, key_reg);
          end else if (header_ready || halt) begin
            state        <= DONE;
            header_valid <= 1'b0;
            done         <= 1'b1;
            overflow     <= header_ready && !fits;
          end
        end
        DONE: begin
          header_valid <= 1'b0;
        end
        default: state <= LOAD_KEY;
      endcase
    end
  end

endmodule

// File: tb/tb_header_generator.sv
// Bench for header_generator: three instances (default, carry growth, narrow overflow) checked
// against a string-based model of key + decimal nonce.
module tb_header_generator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic k0_valid, k0_last, k0_ready, halt0, hv0, hr0, done0, ovf0;
  logic [7:0] k0_data;
  logic [127:0] hd0;
  logic [31:0] hi0;

  logic k1_valid, k1_last, k1_ready, halt1, hv1, hr1, done1, ovf1;
  logic [7:0] k1_data;
  logic [127:0] hd1;
  logic [31:0] hi1;

  logic k2_valid, k2_last, k2_ready, halt2, hv2, hr2, done2, ovf2;
  logic [7:0] k2_data;
  logic [47:0] hd2;
  logic [31:0] hi2;

  header_generator #(.BLOCK_HEADER_WIDTH(128), .INDEX_WIDTH(32), .START_VALUE(609043)) u0 (
    .clk(clk), .reset(reset), .key_valid(k0_valid), .key_data(k0_data), .key_last(k0_last),
    .key_ready(k0_ready), .halt(halt0), .header_valid(hv0), .header_ready(hr0),
    .header_data(hd0), .header_index(hi0), .done(done0), .overflow(ovf0));

  header_generator #(.BLOCK_HEADER_WIDTH(128), .INDEX_WIDTH(32), .START_VALUE(998)) u1 (
    .clk(clk), .reset(reset), .key_valid(k1_valid), .key_data(k1_data), .key_last(k1_last),
    .key_ready(k1_ready), .halt(halt1), .header_valid(hv1), .header_ready(hr1),
    .header_data(hd1), .header_index(hi1), .done(done1), .overflow(ovf1));

  header_generator #(.BLOCK_HEADER_WIDTH(48), .INDEX_WIDTH(32), .START_VALUE(98)) u2 (
    .clk(clk), .reset(reset), .key_valid(k2_valid), .key_data(k2_data), .key_last(k2_last),
    .key_ready(k2_ready), .halt(halt2), .header_valid(hv2), .header_ready(hr2),
    .header_data(hd2), .header_index(hi2), .done(done2), .overflow(ovf2));

  int tests = 0;
  int fails = 0;
  longint exp_n;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header = text of key followed by decimal nonce, last character in byte 0.
  function automatic logic [127:0] exp_hdr(string key, longint nonce);
    string s;
    logic [127:0] h;
    s = $sformatf("%s%0d", key, nonce);
    h = '0;
    for (int i = 0; i < s.len(); i++) h[8*i +: 8] = s[s.len()-1-i];
    return h;
  endfunction

  task automatic load_key(int which, string k);
    for (int i = 0; i < k.len(); i++) begin
      case (which)
        0: begin k0_valid = 1'b1; k0_data = k[i]; k0_last = (i == k.len()-1); end
        1: begin k1_valid = 1'b1; k1_data = k[i]; k1_last = (i == k.len()-1); end
        default: begin k2_valid = 1'b1; k2_data = k[i]; k2_last = (i == k.len()-1); end
      endcase
      @(negedge clk);
    end
    k0_valid = 1'b0; k0_last = 1'b0;
    k1_valid = 1'b0; k1_last = 1'b0;
    k2_valid = 1'b0; k2_last = 1'b0;
  endtask

  // One EMIT cycle on u0: compare against the model, then drive ready/halt plus ignored key noise.
  task automatic cyc0(string key, bit rdy, bit hlt);
    check("u0_valid", hv0, 1);
    check("u0_data", hd0, exp_hdr(key, exp_n));
    check("u0_index", hi0, exp_n);
    hr0 = rdy;
    halt0 = hlt;
    k0_valid = 1'($urandom);
    k0_data = 8'($urandom);
    k0_last = 1'($urandom);
    @(negedge clk);
    if (rdy) exp_n++;
  endtask

  initial begin
    string key;
    reset = 1'b1;
    {k0_valid, k0_last, halt0, hr0, k0_data} = '0;
    {k1_valid, k1_last, halt1, hr1, k1_data} = '0;
    {k2_valid, k2_last, halt2, hr2, k2_data} = '0;
    @(negedge clk);
    check("rst_key_ready", k0_ready, 1);
    check("rst_valid", hv0, 0);
    check("rst_data", hd0, 0);
    check("rst_index", hi0, 0);
    check("rst_done", done0, 0);
    check("rst_overflow", ovf0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Carry growth 999 -> 1000
    hr1 = 1'b1;
    load_key(1, "ab");
    for (longint v = 998; v <= 1000; v++) begin
      check("carry_valid", hv1, 1);
      check("carry_data", hd1, exp_hdr("ab", v));
      check("carry_index", hi1, v);
      @(negedge clk);
    end
    hr1 = 1'b0;

    // Narrow header overflow: abcd98, abcd99, then done
    hr2 = 1'b1;
    load_key(2, "abcd");
    for (longint v = 98; v <= 99; v++) begin
      check("ovf_valid", hv2, 1);
      check("ovf_data", hd2, exp_hdr("abcd", v));
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check("ovf_no_header", hv2, 0);
      check("ovf_done", done2, 1);
      check("ovf_flag", ovf2, 1);
      @(negedge clk);
    end

    // Main key, first headers, backpressure, random ready, halt at 609050
    load_key(0, "abcdef");
    exp_n = 609043;
    check("first_hdr", hd0, exp_hdr("abcdef", 609043));
    cyc0("abcdef", 1, 0);
    check("byte0", hd0[7:0], 8'h34);
    for (int i = 0; i < 5; i++) cyc0("abcdef", 0, 0);
    for (int i = 0; i < 200 && exp_n != 609050; i++) cyc0("abcdef", 1'($urandom), 0);
    check("reach_609050", exp_n, 609050);
    cyc0("abcdef", 1, 1);
    check("halt_valid", hv0, 0);
    check("halt_done", done0, 1);
    check("halt_overflow", ovf0, 0);
    check("halt_key_ready", k0_ready, 0);
    halt0 = 1'b0; hr0 = 1'b0; k0_valid = 1'b0; k0_last = 1'b0;

    // Random long key, reset mid-EMIT at 609047, reload xyz
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key = "";
    for (int i = 0, len = $urandom_range(6, 8); i < len; i++)
      key = $sformatf("%s%c", key, 8'(97 + $urandom_range(0, 25)));
    load_key(0, key);
    exp_n = 609043;
    for (int i = 0; i < 200 && exp_n != 609047; i++) cyc0(key, 1'($urandom), 0);
    check("reach_609047", exp_n, 609047);
    hr0 = 1'b0; k0_valid = 1'b0; k0_last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_key_ready", k0_ready, 1);
    check("mid_rst_valid", hv0, 0);
    check("mid_rst_data", hd0, 0);
    check("mid_rst_index", hi0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_overflow", ovf0, 0);
    reset = 1'b0;
    load_key(0, "xyz");
    exp_n = 609043;
    check("reload_upper_clear", hd0[127:72], 0);
    for (int i = 0; i < 40; i++) cyc0("xyz", 1'($urandom), 0);
    hr0 = 1'b0; k0_valid = 1'b0; k0_last = 1'b0;

    // START_VALUE does not fit after the key: straight to done with overflow, no header
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_key(2, "abcde");
    for (int i = 0; i < 2; i++) begin
      check("nofit_valid", hv2, 0);
      check("nofit_done", done2, 1);
      check("nofit_overflow", ovf2, 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
